itg_merge: RTL and testbench
============================

Name: itg_merge

Overview:
- Streaming merge stage that feeds the integration net.
- Aligns the encoder skip-feature stream with the later-arriving unpooled decoder stream using a FIFO.
- Combines the two per pixel, either by channel concatenation or by element-wise saturating add, selected by parameter.
- Output is the packed pixel vector plus vcnt/hcnt/enable consumed by the next conv layer.

Parameters:
- W_HEIGHT, 480, window height; V_BITW = ceil(log2(W_HEIGHT)).
- W_WIDTH, 640, window width; H_BITW = ceil(log2(W_WIDTH)).
- DEC_UNITS, 12, channels on the decoder stream.
- SKIP_UNITS, 12, channels on the skip stream.
- FIXED_BITW, 13, signed fixed-point width per channel (5 int + 8 frac).
- DEPTH, 1024, FIFO depth in pixels; power of 2, ≥ 2.
- MODE, 0, 0 = concat {dec, skip}; 1 = saturating add (requires DEC_UNITS == SKIP_UNITS; otherwise elaboration error via generate).
- OUT_UNITS (localparam) = MODE ? DEC_UNITS : DEC_UNITS + SKIP_UNITS.

Ports:
- clock  in  1  system clock.
- n_rst  in  1  synchronous reset, active-high (1 = reset) despite the name.
- skip_enable  in  1  skip pixel valid.
- skip_data  in  [0:SKIP_UNITS*FIXED_BITW-1]  skip channels, unit 0 at MSB end.
- skip_vcnt  in  V_BITW  skip pixel row.
- skip_hcnt  in  H_BITW  skip pixel column.
- dec_enable  in  1  decoder pixel valid.
- dec_data  in  [0:DEC_UNITS*FIXED_BITW-1]  decoder channels.
- dec_vcnt  in  V_BITW  decoder pixel row.
- dec_hcnt  in  H_BITW  decoder pixel column.
- out_enable  out  1  merged pixel valid.
- out_data  out  [0:OUT_UNITS*FIXED_BITW-1]  merged channels.
- out_vcnt  out  V_BITW  copy of dec_vcnt.
- out_hcnt  out  H_BITW  copy of dec_hcnt.
- fill  out  log2(DEPTH)+1  current FIFO occupancy.
- err_ovf  out  1  sticky overflow flag.
- err_unf  out  1  sticky underflow flag.
- err_coord  out  1  sticky coordinate-mismatch flag.

Behaviour:
- Reset, synchronous, active on n_rst = 1:
  - all outputs 0;
  - read/write pointers and fill 0;
  - sticky flags cleared.
  - Reset mid-frame discards FIFO contents; the first cycle after reset accepts new input.
- FIFO: synchronous-read dual-port RAM. Each entry stores {skip_data, skip_vcnt, skip_hcnt}.
- Push: on skip_enable when not full, or when full and pop happens in the same cycle.
  - Push while full without a pop drops the pixel, leaves fill unchanged and sets err_ovf.
- Pop: on dec_enable when fill > 0, or fill == 0 with simultaneous push (bypass path: the incoming skip word is used directly).
  - dec_enable with fill == 0 and no push: skip operand forced to 0, err_unf set, output still produced.
- Simultaneous push and pop: fill unchanged.
- Pointers wrap modulo DEPTH.
- Latency: fixed 2 cycles from dec_enable to out_enable (RAM read stage + combine register).
  - out_vcnt/out_hcnt are dec coordinates delayed 2 cycles.
  - Throughput: 1 pixel/cycle.
- Coordinate check: if the popped entry's {vcnt, hcnt} ≠ {dec_vcnt, dec_hcnt}, set err_coord. Data is still merged; no resync.
- MODE 0: out_data = {dec unit0..N-1, skip unit0..M-1}; no arithmetic.
- MODE 1: per unit, signed FIXED_BITW+1-bit sum.
  - Saturate to max 2^(FIXED_BITW-1)-1 or min -2^(FIXED_BITW-1).
- Sticky flags clear only on reset.
- fill updates 1 cycle after the push/pop event.

Test Plan:
1. Reset, then 8 skip pixels at (0,0..7); 3 idle cycles; 8 dec pixels at (0,0..7), MODE 0:
   - out_enable high exactly 2 cycles after each dec_enable;
   - out_data = {dec, skip} bit-exact;
   - fill goes 8→0;
   - no flags set.
2. DEPTH=4: push 5 skip pixels with no pops → err_ovf=1, fill=4, 5th pixel lost. Subsequent pops return pixels 0..3.
3. dec_enable on empty FIFO, no push → skip half of out_data = 0, err_unf=1.
   - Then simultaneous push+pop on empty → bypass data correct, fill stays 0.
4. MODE 1, unit values dec=0x0FFF, skip=0x0001 → 0x0FFF (positive saturation).
   - dec=0x1000, skip=0x1FFF → 0x1000 (negative saturation).
   - dec=0x0100, skip=0x0080 → 0x0180.
5. Skip pixel (0,5) queued, dec pixel (0,6) → err_coord=1, output still issued at +2 cycles.
6. Assert n_rst mid-stream with fill=3 → all outputs and flags 0 next cycle, fill=0. Post-reset push/pop sequence behaves as in scenario 1.

Source files
------------

// File: rtl/itg_merge.sv
// Skip/decoder stream merge feeding the integration net: FIFO-aligns skip pixels
// to the later decoder stream, then concatenates or saturating-adds per pixel.
module itg_merge #(
  parameter  int W_HEIGHT   = 480,
  parameter  int W_WIDTH    = 640,
  parameter  int DEC_UNITS  = 12,
  parameter  int SKIP_UNITS = 12,
  parameter  int FIXED_BITW = 13,
  parameter  int DEPTH      = 1024,
  parameter  int MODE       = 0,
  localparam int V_BITW     = $clog2(W_HEIGHT),
  localparam int H_BITW     = $clog2(W_WIDTH),
  localparam int AW         = $clog2(DEPTH),
  localparam int OUT_UNITS  = (MODE != 0) ? DEC_UNITS : DEC_UNITS + SKIP_UNITS
) (
  input  logic                                clock,
  input  logic                                n_rst,
  input  logic                                skip_enable,
  input  logic [0:SKIP_UNITS*FIXED_BITW-1]    skip_data,
  input  logic [V_BITW-1:0]                   skip_vcnt,
  input  logic [H_BITW-1:0]                   skip_hcnt,
  input  logic                                dec_enable,
  input  logic [0:DEC_UNITS*FIXED_BITW-1]     dec_data,
  input  logic [V_BITW-1:0]                   dec_vcnt,
  input  logic [H_BITW-1:0]                   dec_hcnt,
  output logic                                out_enable,
  output logic [0:OUT_UNITS*FIXED_BITW-1]     out_data,
  output logic [V_BITW-1:0]                   out_vcnt,
  output logic [H_BITW-1:0]                   out_hcnt,
  output logic [AW:0]                         fill,
  output logic                                err_ovf,
  output logic                                err_unf,
  output logic                                err_coord
);
  localparam int SW     = SKIP_UNITS * FIXED_BITW;
  localparam int DW     = DEC_UNITS * FIXED_BITW;
  localparam int OW     = OUT_UNITS * FIXED_BITW;
  localparam int STAGES = 2;

  typedef struct packed {
    logic [SW-1:0]     data;
    logic [V_BITW-1:0] vcnt;
    logic [H_BITW-1:0] hcnt;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            wr_ent, ram_q, byp_q, pop_ent;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              full, empty, pop_ram, bypass, wr_en;
  logic [STAGES:1]   vld_pipe;
  logic              s1_byp, s1_zero;
  logic [DW-1:0]     s1_dec;
  logic [V_BITW-1:0] s1_vcnt;
  logic [H_BITW-1:0] s1_hcnt;
  logic [SW-1:0]     skip_op;
  logic [OW-1:0]     comb_data;
  logic              coord_bad;

  assign wr_ent  = {skip_data, skip_vcnt, skip_hcnt};
  assign full    = (fill == (AW+1)'(DEPTH));
  assign empty   = (fill == '0);
  assign pop_ram = dec_enable & ~empty;
  // empty FIFO with a same-cycle push: skip word goes straight to the merge, RAM untouched
  assign bypass  = dec_enable & empty & skip_enable;
  assign wr_en   = skip_enable & ~bypass & (~full | pop_ram);

  assign out_enable = vld_pipe[STAGES];

  // read-before-write so a full FIFO can push and pop the same slot in one cycle
  always_ff @(posedge clock) begin
    if (wr_en)   mem[wr_ptr] <= wr_ent;
    if (pop_ram) ram_q       <= mem[rd_ptr];
  end

  always_ff @(posedge clock) begin
    if (n_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      vld_pipe  <= '0;
      s1_byp    <= 1'b0;
      s1_zero   <= 1'b0;
      s1_dec    <= '0;
      s1_vcnt   <= '0;
      s1_hcnt   <= '0;
      byp_q     <= '0;
      out_data  <= '0;
      out_vcnt  <= '0;
      out_hcnt  <= '0;
      err_ovf   <= 1'b0;
      err_unf   <= 1'b0;
      err_coord <= 1'b0;
    end else begin
      if (wr_en)   wr_ptr <= wr_ptr + AW'(1);
      if (pop_ram) rd_ptr <= rd_ptr + AW'(1);
      fill     <= fill + (AW+1)'(wr_en) - (AW+1)'(pop_ram);
      vld_pipe <= {vld_pipe[STAGES-1:1], dec_enable};
      if (dec_enable) begin
        s1_dec  <= dec_data;
        s1_vcnt <= dec_vcnt;
        s1_hcnt <= dec_hcnt;
        s1_byp  <= bypass;
        s1_zero <= empty & ~skip_enable;
        byp_q   <= wr_ent;
      end
      if (skip_enable & full & ~pop_ram)     err_ovf <= 1'b1;
      if (dec_enable & empty & ~skip_enable) err_unf <= 1'b1;
      if (vld_pipe[1]) begin
        out_data <= comb_data;
        out_vcnt <= s1_vcnt;
        out_hcnt <= s1_hcnt;
        if (coord_bad) err_coord <= 1'b1;
      end
    end
  end

  always_comb begin
    pop_ent   = s1_byp ? byp_q : ram_q;
    skip_op   = s1_zero ? '0 : pop_ent.data;
    coord_bad = ~s1_zero & ({pop_ent.vcnt, pop_ent.hcnt} != {s1_vcnt, s1_hcnt});
  end

  if (MODE == 0) begin : g_cat
    assign comb_data = {s1_dec, skip_op};
  end else begin : g_add
    if (DEC_UNITS != SKIP_UNITS) begin : g_bad_cfg
      $error("itg_merge: MODE 1 needs DEC_UNITS == SKIP_UNITS");
    end
    for (genvar u = 0; u < DEC_UNITS; u++) begin : g_lane
      logic [FIXED_BITW-1:0] a, b;
      logic [FIXED_BITW:0]   sum;
      assign a   = s1_dec[DW-1-u*FIXED_BITW -: FIXED_BITW];
      assign b   = skip_op[SW-1-u*FIXED_BITW -: FIXED_BITW];
      assign sum = {a[FIXED_BITW-1], a} + {b[FIXED_BITW-1], b};
      // sign bits disagree -> overflow; clamp toward the true sign
      assign comb_data[OW-1-u*FIXED_BITW -: FIXED_BITW] =
        (sum[FIXED_BITW] != sum[FIXED_BITW-1]) ?
          {sum[FIXED_BITW], {(FIXED_BITW-1){~sum[FIXED_BITW]}}} : sum[FIXED_BITW-1:0];
    end
  end

endmodule

// File: tb/tb_itg_merge.sv
// Randomized + directed bench for itg_merge: three configurations driven in lockstep
// (concat/deep, concat/depth 4, saturating add) against a queue-based reference model.
module tb_itg_merge;
  localparam int FB = 13, UNITS = 2, SW = UNITS*FB, VB = 9, HB = 10;

  logic clock = 1'b0, n_rst = 1'b1;
  logic se = 1'b0, de = 1'b0;
  logic [SW-1:0] sd = '0, dd = '0;
  logic [VB-1:0] sv = '0, dv = '0;
  logic [HB-1:0] sh = '0, dh = '0;

  logic oe_a, oe_b, oe_c;
  logic [2*SW-1:0] od_a, od_b;
  logic [SW-1:0] od_c;
  logic [VB-1:0] ov_a, ov_b, ov_c;
  logic [HB-1:0] oh_a, oh_b, oh_c;
  logic [4:0] fill_a;
  logic [2:0] fill_b;
  logic [3:0] fill_c;
  logic ovf_a, unf_a, crd_a, ovf_b, unf_b, crd_b, ovf_c, unf_c, crd_c;

  always #5 clock = ~clock;

  itg_merge #(.DEC_UNITS(UNITS), .SKIP_UNITS(UNITS), .FIXED_BITW(FB), .DEPTH(16), .MODE(0)) u_dut_a (
    .clock(clock), .n_rst(n_rst), .skip_enable(se), .skip_data(sd), .skip_vcnt(sv), .skip_hcnt(sh),
    .dec_enable(de), .dec_data(dd), .dec_vcnt(dv), .dec_hcnt(dh), .out_enable(oe_a), .out_data(od_a),
    .out_vcnt(ov_a), .out_hcnt(oh_a), .fill(fill_a), .err_ovf(ovf_a), .err_unf(unf_a), .err_coord(crd_a));
  itg_merge #(.DEC_UNITS(UNITS), .SKIP_UNITS(UNITS), .FIXED_BITW(FB), .DEPTH(4), .MODE(0)) u_dut_b (
    .clock(clock), .n_rst(n_rst), .skip_enable(se), .skip_data(sd), .skip_vcnt(sv), .skip_hcnt(sh),
    .dec_enable(de), .dec_data(dd), .dec_vcnt(dv), .dec_hcnt(dh), .out_enable(oe_b), .out_data(od_b),
    .out_vcnt(ov_b), .out_hcnt(oh_b), .fill(fill_b), .err_ovf(ovf_b), .err_unf(unf_b), .err_coord(crd_b));
  itg_merge #(.DEC_UNITS(UNITS), .SKIP_UNITS(UNITS), .FIXED_BITW(FB), .DEPTH(8), .MODE(1)) u_dut_c (
    .clock(clock), .n_rst(n_rst), .skip_enable(se), .skip_data(sd), .skip_vcnt(sv), .skip_hcnt(sh),
    .dec_enable(de), .dec_data(dd), .dec_vcnt(dv), .dec_hcnt(dh), .out_enable(oe_c), .out_data(od_c),
    .out_vcnt(ov_c), .out_hcnt(oh_c), .fill(fill_c), .err_ovf(ovf_c), .err_unf(unf_c), .err_coord(crd_c));

  typedef struct packed { logic [SW-1:0] d; logic [VB-1:0] v; logic [HB-1:0] h; } ent_t;
  typedef struct packed { int due; logic [2*SW-1:0] d; logic [VB-1:0] v; logic [HB-1:0] h; logic cerr; } exp_t;

  ent_t fq[3][$];
  exp_t eq[3][$];
  bit   m_ovf[3], m_unf[3], m_crd[3];
  int   dep[3] = '{16, 4, 8};
  int   cyc = 0, n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // instance 2 adds with saturation; the others concatenate {dec, skip}
  function automatic logic [2*SW-1:0] merge(input int k, input logic [SW-1:0] dv_i, input logic [SW-1:0] sv_i);
    logic [2*SW-1:0] r;
    int a, b, s;
    if (k != 2) return {dv_i, sv_i};
    r = '0;
    for (int u = 0; u < UNITS; u++) begin
      a = int'($signed(dv_i[SW-1-u*FB -: FB]));
      b = int'($signed(sv_i[SW-1-u*FB -: FB]));
      s = a + b;
      if (s > 4095)  s = 4095;
      if (s < -4096) s = -4096;
      r[SW-1-u*FB -: FB] = s[FB-1:0];
    end
    return r;
  endfunction

  task automatic model_step(input int k);
    ent_t e;
    bit byp, ce;
    byp = 0; ce = 0; e = '0;
    if (n_rst) begin
      fq[k].delete(); eq[k].delete();
      m_ovf[k] = 0; m_unf[k] = 0; m_crd[k] = 0;
      return;
    end
    if (de) begin
      if (fq[k].size() > 0) begin
        e = fq[k].pop_front();
        ce = (e.v != dv) || (e.h != dh);
      end else if (se) begin
        e = '{sd, sv, sh};
        byp = 1;
        ce = (sv != dv) || (sh != dh);
      end else m_unf[k] = 1;
      eq[k].push_back('{cyc + 1, merge(k, dd, e.d), dv, dh, ce});
    end
    if (se && !byp) begin
      if (fq[k].size() < dep[k]) fq[k].push_back('{sd, sv, sh});
      else m_ovf[k] = 1;
    end
  endtask

  task automatic check_dut(input int k);
    logic oe; logic [2*SW-1:0] od; logic [VB-1:0] ov; logic [HB-1:0] oh; int fl; logic [2:0] fg;
    exp_t x; bit ee; string t;
    case (k)
      0: begin oe = oe_a; od = od_a; ov = ov_a; oh = oh_a; fl = int'(fill_a); fg = {ovf_a, unf_a, crd_a}; end
      1: begin oe = oe_b; od = od_b; ov = ov_b; oh = oh_b; fl = int'(fill_b); fg = {ovf_b, unf_b, crd_b}; end
      default: begin oe = oe_c; od = {{SW{1'b0}}, od_c}; ov = ov_c; oh = oh_c; fl = int'(fill_c); fg = {ovf_c, unf_c, crd_c}; end
    endcase
    t  = $sformatf("dut%0d", k);
    ee = (eq[k].size() > 0) && (eq[k][0].due == cyc);
    chk({t, "_oe"}, oe, ee);
    if (ee) begin
      x = eq[k].pop_front();
      if (x.cerr) m_crd[k] = 1;
      chk({t, "_data"}, od, x.d);
      chk({t, "_vcnt"}, ov, x.v);
      chk({t, "_hcnt"}, oh, x.h);
    end
    chk({t, "_fill"}, fl, fq[k].size());
    chk({t, "_flags"}, fg, {m_ovf[k], m_unf[k], m_crd[k]});
  endtask

  task automatic tick();
    @(posedge clock);
    cyc++;
    for (int k = 0; k < 3; k++) model_step(k);
    #1;
    for (int k = 0; k < 3; k++) check_dut(k);
  endtask

  task automatic io(input bit s_en, input int s_v, input int s_h, input logic [SW-1:0] s_d,
                    input bit d_en, input int d_v, input int d_h, input logic [SW-1:0] d_d);
    se = s_en; sv = VB'(s_v); sh = HB'(s_h); sd = s_d;
    de = d_en; dv = VB'(d_v); dh = HB'(d_h); dd = d_d;
    tick();
  endtask

  task automatic idle(input int n);
    se = 0; de = 0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    se = 0; de = 0; n_rst = 1;
    tick();
    n_rst = 0;
  endtask

  task automatic frame8(input string tag);
    for (int i = 0; i < 8; i++) io(1, 0, i, SW'($urandom), 0, 0, 0, '0);
    idle(3);
    chk({tag, "_fill8"}, fill_a, 8);
    for (int i = 0; i < 8; i++) io(0, 0, 0, '0, 1, 0, i, SW'($urandom));
    idle(3);
    chk({tag, "_fill0"}, fill_a, 0);
    chk({tag, "_noflags"}, {ovf_a, unf_a, crd_a}, 3'b000);
  endtask

  initial begin
    int sc, dc, h;
    n_rst = 1;
    tick(); tick();
    n_rst = 0;
    chk("rst_state", {oe_a, fill_a, ovf_a, unf_a, crd_a, od_a}, '0);

    // basic aligned frame
    frame8("s1");

    // overflow on the depth-4 instance
    do_reset();
    for (int i = 0; i < 5; i++) io(1, 0, i, SW'($urandom), 0, 0, 0, '0);
    chk("s2_fill_full", fill_b, 4);
    chk("s2_ovf", ovf_b, 1);
    for (int i = 0; i < 4; i++) io(0, 0, 0, '0, 1, 0, i, SW'($urandom));
    idle(2);
    chk("s2_no_coord", crd_b, 0);

    // underflow, then bypass on an empty FIFO
    do_reset();
    io(0, 0, 0, '0, 1, 0, 0, SW'($urandom));
    idle(2);
    chk("s3_unf", unf_a, 1);
    io(1, 0, 1, SW'($urandom), 1, 0, 1, SW'($urandom));
    idle(2);
    chk("s3_byp_fill", fill_a, 0);

    // saturation corners on the add instance
    do_reset();
    io(1, 0, 0, {13'h0001, 13'h1FFF}, 0, 0, 0, '0);
    io(0, 0, 0, '0, 1, 0, 0, {13'h0FFF, 13'h1000});
    idle(1);
    chk("s4_sat", od_c, {13'h0FFF, 13'h1000});
    io(1, 0, 1, {13'h0080, 13'h0080}, 1, 0, 1, {13'h0100, 13'h0100});
    idle(1);
    chk("s4_add", od_c, {13'h0180, 13'h0180});

    // coordinate mismatch still produces output
    do_reset();
    io(1, 0, 5, SW'($urandom), 0, 0, 0, '0);
    io(0, 0, 0, '0, 1, 0, 6, SW'($urandom));
    idle(1);
    chk("s5_oe", oe_a, 1);
    chk("s5_coord", crd_a, 1);

    // reset with data in flight
    do_reset();
    for (int i = 0; i < 3; i++) io(1, 0, i, SW'($urandom), 0, 0, 0, '0);
    chk("s6_fill3", fill_a, 3);
    se = 1; de = 1; n_rst = 1;
    tick();
    n_rst = 0;
    chk("s6_rst_out", {oe_a, od_a, ov_a, oh_a}, '0);
    chk("s6_rst_fill", fill_a, 0);
    chk("s6_rst_flags", {ovf_a, unf_a, crd_a}, 3'b000);
    frame8("s6");

    // random traffic with occasional coordinate glitches and one mid-run reset
    do_reset();
    sc = 0; dc = 0;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        do_reset();
        sc = 0; dc = 0;
      end
      se = $urandom_range(0, 1) != 0;
      de = $urandom_range(0, 1) != 0;
      sd = SW'($urandom); dd = SW'($urandom);
      sv = VB'(sc / 640); sh = HB'(sc % 640);
      h  = dc % 640;
      if ($urandom_range(0, 49) == 0) h = (h + 1) % 640;
      dv = VB'(dc / 640); dh = HB'(h);
      if (se) sc++;
      if (de) dc++;
      tick();
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
